// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax numerator sequencer: FSM encoding, LUT geometry
// and the saturating accumulator helper.
package softmax_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t EXP   = 2'd2;
  localparam state_t DRAIN = 2'd3;

  localparam int LUT_MAX_ADDR = 15;
  localparam int LUT_IDX_W    = 5;

  // Accumulator add that pins at 2^width-1 instead of wrapping (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] val,
                                          input int          width);
    logic [32:0] total;
    logic [32:0] limit;
    total = {1'b0, acc} + {1'b0, val};
    limit = (33'd1 << width) - 33'd1;
    return (total > limit) ? limit[31:0] : total[31:0];
  endfunction

endpackage

// File: rtl/softmax_exp_ctrl.sv
// Softmax numerator sequencer: loads a score vector, finds its max, walks exp_lut to
// produce exp(x_i - max), then streams the numerators out with their saturated sum.
// Optional clamp counter port enabled by defining SOFTMAX_CLAMP_CNT_EN.
module softmax_exp_ctrl
  import softmax_pkg::*;
#(
  parameter  int VEC_LEN   = 16,
  parameter  int IN_W      = 8,
  parameter  int LUT_DEPTH = LUT_MAX_ADDR + 1,
  parameter  int VAL_W     = 16,
  parameter  int SUM_W     = 24,
  localparam int LEN_W     = $clog2(VEC_LEN + 1),
  localparam int ADDR_W    = $clog2(VEC_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic [LUT_IDX_W-1:0]   lut_index,
  input  logic [VAL_W-1:0]       lut_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VAL_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   sum_valid,
  output logic [SUM_W-1:0]       sum,
  output logic                   busy
`ifdef SOFTMAX_CLAMP_CNT_EN
  ,
  output logic [LEN_W-1:0]       clamp_cnt
`endif
);

  state_t                 state_reg, state_next;
  logic [LEN_W-1:0]       len_reg, len_next;
  logic [LEN_W-1:0]       idx_reg, idx_next;
  logic signed [IN_W-1:0] max_reg, max_next;
  logic [SUM_W-1:0]       sum_reg, sum_next;

  logic signed [IN_W-1:0] sbuf [VEC_LEN];
  logic [VAL_W-1:0]       ebuf [VEC_LEN];

  logic [ADDR_W-1:0]      rd_addr, cap_addr;
  logic signed [IN_W:0]   diff;
  logic [IN_W:0]          mag;
  logic                   clamp_hit, exp_issue, exp_capture, start_acc, last_elem;

  // One counter serves as write pointer (LOAD), issue cycle (EXP) and read pointer (DRAIN).
  assign rd_addr     = ADDR_W'(idx_reg);
  assign cap_addr    = ADDR_W'(idx_reg - LEN_W'(1));
  assign diff        = {sbuf[rd_addr][IN_W-1], sbuf[rd_addr]} - {max_reg[IN_W-1], max_reg};
  assign mag         = '0 - $unsigned(diff);
  assign clamp_hit   = mag > (IN_W+1)'(LUT_DEPTH - 1);
  assign exp_issue   = (state_reg == EXP) && (idx_reg != len_reg);
  assign exp_capture = (state_reg == EXP) && (idx_reg != '0);
  assign start_acc   = (state_reg == IDLE) && start && (len != '0);
  assign last_elem   = idx_reg == (len_reg - LEN_W'(1));

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    max_next   = max_reg;
    sum_next   = sum_reg;
    case (state_reg)
      IDLE: begin
        if (start_acc) begin
          state_next = LOAD;
          len_next   = (len > LEN_W'(VEC_LEN)) ? LEN_W'(VEC_LEN) : len;
          idx_next   = '0;
          sum_next   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          idx_next = idx_reg + LEN_W'(1);
          if ((idx_reg == '0) || (in_data > max_reg)) max_next = in_data;
          if (last_elem) begin
            state_next = EXP;
            idx_next   = '0;
          end
        end
      end
      EXP: begin
        // The LUT answers one cycle late, so capture trails issue by one step.
        if (exp_capture) sum_next = SUM_W'(sat_add(32'(sum_reg), 32'(lut_value), SUM_W));
        if (idx_reg == len_reg) begin
          state_next = DRAIN;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + LEN_W'(1);
        end
      end
      default: begin
        if (out_ready) begin
          if (last_elem) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + LEN_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      max_reg   <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      max_reg   <= max_next;
      sum_reg   <= sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_reg == LOAD) && in_valid) sbuf[rd_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (exp_capture) ebuf[cap_addr] <= lut_value;
  end

`ifdef SOFTMAX_CLAMP_CNT_EN
  logic [LEN_W-1:0] clamp_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      clamp_cnt_reg <= '0;
    end else if (exp_issue && clamp_hit) begin
      clamp_cnt_reg <= clamp_cnt_reg + LEN_W'(1);
    end
  end

  assign clamp_cnt = clamp_cnt_reg;
`endif

  assign lut_index = exp_issue ? (clamp_hit ? LUT_IDX_W'(LUT_DEPTH - 1) : LUT_IDX_W'(mag))
                               : '0;
  assign in_ready  = state_reg == LOAD;
  assign busy      = state_reg != IDLE;
  assign out_valid = state_reg == DRAIN;
  assign sum_valid = state_reg == DRAIN;
  assign out_data  = out_valid ? ebuf[rd_addr] : '0;
  assign out_last  = out_valid && last_elem;
  assign sum       = sum_reg;

endmodule

// File: doc/softmax_exp_ctrl.md
Name: softmax_exp_ctrl

Overview:
Sequencer that drives the shared 16-entry exp LUT (`exp_lut`, 1-cycle registered read) to compute the softmax numerators exp(x_i − max) and their sum for one score vector.
- Accepts a vector of signed scores over a valid/ready stream and finds the max.
- Issues one LUT read per element and buffers the results.
- Streams the results out with backpressure and presents the saturated sum for the downstream normaliser.
- Sits between the score producer and the divide/normalise stage.

Parameters:
- VEC_LEN, 16, maximum elements per vector (internal buffer depth).
- IN_W, 8, signed score width.
- LUT_DEPTH, 16, LUT entries; address k holds exp(−k).
- VAL_W, 16, LUT value / output width.
- SUM_W, 24, accumulator width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin vector; sampled in IDLE only
- len  in  $clog2(VEC_LEN+1)  element count, sampled with start
- in_valid  in  1  score valid
- in_ready  out  1  high in LOAD only
- in_data  in  IN_W  signed score
- lut_index  out  5  LUT address (unsigned magnitude 0..LUT_DEPTH−1)
- lut_value  in  VAL_W  LUT data, valid 1 cycle after lut_index
- out_valid  out  1  numerator valid
- out_ready  in  1  downstream accept
- out_data  out  VAL_W  exp(x_i − max)
- out_last  out  1  marks final element
- sum_valid  out  1  sum stable (DRAIN)
- sum  out  SUM_W  saturated sum of numerators
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`reset`). On reset, from any state including mid-vector, the FSM returns to IDLE. All outputs are 0 (lut_index=0, sum=0), max/count/sum registers are cleared, and buffer contents are don't-care.
- IDLE:
  - start=1 with len≥1 → LOAD; len_r = min(len, VEC_LEN); count=0.
  - start with len=0 → ignored, stays IDLE.
- LOAD:
  - in_ready=1. On in_valid&&in_ready, store in_data in buf[count], update max (first element initialises max), count++.
  - After len_r accepts → EXP. in_ready deasserts the cycle after the last accept.
  - start is ignored while busy.
- EXP:
  - Cycle t (t=0..len_r−1): d = buf[t] − max, computed in IN_W+1 bits (d ≤ 0). lut_index = min(−d, LUT_DEPTH−1), i.e. clamp at 15.
  - Cycle t+1: capture lut_value into ebuf[t] and add it to sum. The sum saturates at 2^SUM_W−1 and never wraps.
  - Phase lasts exactly len_r+1 cycles, then → DRAIN.
  - lut_index returns to 0 outside EXP.
- DRAIN:
  - sum_valid=1 for the whole state, sum held constant.
  - out_valid=1, out_data=ebuf[rd]. Advance rd only on out_valid&&out_ready. out_data and out_last stay stable while stalled.
  - out_last=1 when rd==len_r−1. The handshake with out_last → IDLE next cycle, and sum_valid drops.
- Element with score == max always yields index 0 (exp(0)).
- Score range −128..127 gives |d| up to 255, which is clamped to 15.
- Throughput per vector: len_r (LOAD, no stalls) + len_r+1 (EXP) + len_r (DRAIN, no stalls) + 1 IDLE cycle.

Optional Feature:
- Macro SOFTMAX_CLAMP_CNT_EN.
- Defined: adds output port clamp_cnt [$clog2(VEC_LEN+1)-1:0].
  - Counts EXP elements whose |d| > LUT_DEPTH−1.
  - Cleared on start accept and on reset; valid with sum_valid.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package softmax_pkg holds:
  - state enum {IDLE, LOAD, EXP, DRAIN};
  - localparams LUT_MAX_ADDR = LUT_DEPTH−1, LUT_IDX_W = 5;
  - a saturating-add function for the sum.
- No sub-module: the buffers are inferred arrays and exp_lut is instantiated beside the controller, not inside it.
- Bench pairs the controller with the real exp_lut and a gold table E[k] loaded from expected_lut.mem.

Test Plan:
- Vector and output, tied out_ready=1:
  - Stimulus: len=4, scores {5,3,5,−10}.
  - lut_index sequence 0,2,0,15 in EXP.
  - out_data E[0],E[2],E[0],E[15]; out_last on 4th only.
  - sum = E[0]+E[2]+E[0]+E[15]; EXP lasts 5 cycles.
- Clamp:
  - Stimulus: len=2, scores {127,−128}.
  - Indices 0,15; output E[0],E[15].
  - With SOFTMAX_CLAMP_CNT_EN: clamp_cnt=1.
- Backpressure: len=16 with random out_ready stalls.
  - out_data/out_last are held while stalled.
  - All 16 values arrive in order; sum_valid stays high throughout DRAIN.
- Saturation: SUM_W=16, len=16, all scores equal.
  - sum = min(16·E[0], 0xFFFF); no wrap.
- Edge cases:
  - start with len=0 → busy stays 0.
  - start during LOAD → ignored.
  - len=20 → clamped to 16 accepts.
- Reset mid-EXP: assert reset for 1 cycle after 3 EXP cycles.
  - Next cycle: IDLE, busy=0, sum=0, lut_index=0.
  - A fresh vector then completes correctly.
